sample_sequencer: RTL
=====================

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter NUM_SAMPLES, default 4: number of training samples held.
REQ-002 Parameter EPOCH_W, default 16: width of the epoch limit and epoch counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port wr_en, input, 1: sample-store write strobe.
REQ-006 Port wr_idx, input, $clog2(NUM_SAMPLES): sample index to write.
REQ-007 Port wr_field, input, 2: field to write; 0 = x0, 1 = x1, 2 = target, 3 = ignored.
REQ-008 Port wr_data, input, 32: Q16.16 value to write.
REQ-009 Port start, input, 1: single-cycle pulse that begins a training run.
REQ-010 Port abort, input, 1: single-cycle pulse that terminates a run.
REQ-011 Port epoch_limit, input, EPOCH_W: number of full passes over all samples; sampled on start.
REQ-012 Port out_valid, output, 1: sample presented to the network.
REQ-013 Port out_ready, input, 1: network has finished a propagate/backpropagate step on the presented sample.
REQ-014 Ports out_x0, out_x1, out_target, output, 32 each: presented sample, Q16.16.
REQ-015 Port out_idx, output, $clog2(NUM_SAMPLES): index of the presented sample.
REQ-016 Port epoch_cnt, output, EPOCH_W: number of completed epochs.
REQ-017 Port busy, output, 1: asserted in PRESENT.
REQ-018 Port done, output, 1: asserted in DONE.

Function
REQ-019 The FSM SHALL have states IDLE, PRESENT and DONE.
REQ-020 IDLE or DONE with start=1 and abort=0: clear idx and epoch_cnt, latch epoch_limit, and go to PRESENT; if the latched limit is 0, go directly to DONE.
REQ-021 out_valid SHALL be 1 exactly while in PRESENT, so it rises one cycle after start.
REQ-022 out_x0, out_x1 and out_target SHALL equal the store contents at out_idx, and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 A transfer occurs on any cycle with out_valid=1 and out_ready=1; out_idx then advances by 1 on the next edge.
REQ-024 When a transfer occurs at idx = NUM_SAMPLES-1, idx SHALL wrap to 0 and epoch_cnt SHALL increment.
REQ-025 When that increment makes epoch_cnt equal the latched limit, the FSM SHALL go to DONE with idx = 0, and out_valid SHALL drop on the same edge.
REQ-026 In DONE, epoch_cnt SHALL hold its final value and done SHALL be 1 until the next start or abort.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge and clear done; epoch_cnt and idx SHALL hold their values.
REQ-028 If abort and start are asserted together, abort SHALL win.
REQ-029 A write with wr_en=1 SHALL commit in IDLE or DONE only; it SHALL be ignored in PRESENT, and wr_field=3 SHALL be ignored.
REQ-030 A write in the same cycle as start SHALL commit and SHALL be visible on the first presented sample.
REQ-031 epoch_cnt SHALL NOT wrap; the limit check stops it at epoch_limit, which is at most 2^EPOCH_W-1.
REQ-032 The block SHALL perform no arithmetic on the data fields; they are passed through bit-exact.

Reset
REQ-033 While rst_n=0, the block SHALL be in IDLE with all store words = 0, idx = 0, epoch_cnt = 0, latched limit = 0, out_valid = 0, busy = 0 and done = 0.
REQ-034 Reset asserted mid-run SHALL abandon the run immediately, with no further transfers.

Structure
REQ-035 Package nn_pkg SHALL hold: typedef fixed_t (32-bit Q16.16), constant FIX_ONE = 32'h00010000, enum sample_field_e, and enum seq_state_e.
REQ-036 The store SHALL be a sub-module sample_store: NUM_SAMPLES x 3 fixed_t registers with one write port and one combinational read port.
REQ-037 The FSM and counters SHALL reside in sample_sequencer.

Verification
REQ-038 Reset, then write samples {1,1,0}, {1,0,1}, {0,1,1}, {0,0,0} (1 = 32'h00010000), epoch_limit = 2, start, out_ready tied 1 -> the bench sees idx 0,1,2,3,0,1,2,3 over 8 consecutive cycles with matching data, then done = 1 and epoch_cnt = 2.
REQ-039 Same setup with out_ready toggled 1 cycle on / 3 cycles off -> out_x0, out_x1 and out_target stay stable during stalls; exactly 8 transfers occur.
REQ-040 Writes issued during PRESENT (wr_data = 32'hDEADBEEF) -> presented data is unchanged; after DONE, the same write commits.
REQ-041 epoch_limit = 0, then start -> the block goes IDLE to DONE in one cycle; out_valid never rises; epoch_cnt = 0.
REQ-042 abort at the 3rd transfer, with start in the same cycle -> IDLE next cycle, out_valid = 0, epoch_cnt = 0; a later start restarts at idx 0.
REQ-043 rst_n pulsed low mid-run -> all outputs read 0 asynchronously and the store reads 0.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the sample sequencer slice
// Purpose: Q16.16 data type, unit constant, store field selector and
//          sequencer state encoding.
package nn_pkg;

    typedef logic [31:0] fixed_t;

    localparam fixed_t FIX_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        FIELD_X0     = 2'd0,
        FIELD_X1     = 2'd1,
        FIELD_TARGET = 2'd2,
        FIELD_NONE   = 2'd3
    } sample_field_e;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_PRESENT = 2'd1,
        SEQ_DONE    = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sample_store.sv
// rtl/sample_store.sv - NUM_SAMPLES x {x0, x1, target} register file
// Purpose: holds the training samples; one write port, one combinational
//          read port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears store)
//   wr_en, wr_idx,        write strobe (already qualified by the caller),
//   wr_field, wr_data     sample index, field select, Q16.16 data
//   rd_idx                read index
//   rd_x0, rd_x1,         stored fields at rd_idx
//   rd_target
module sample_store
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int IDX_W       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_field,
    input  fixed_t           wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output fixed_t           rd_x0,
    output fixed_t           rd_x1,
    output fixed_t           rd_target
);

    fixed_t mem_x0  [NUM_SAMPLES];
    fixed_t mem_x1  [NUM_SAMPLES];
    fixed_t mem_tgt [NUM_SAMPLES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                mem_x0[i]  <= '0;
                mem_x1[i]  <= '0;
                mem_tgt[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < NUM_SAMPLES)) begin
            case (sample_field_e'(wr_field))
                FIELD_X0:     mem_x0[wr_idx]  <= wr_data;
                FIELD_X1:     mem_x1[wr_idx]  <= wr_data;
                FIELD_TARGET: mem_tgt[wr_idx] <= wr_data;
                default:      ;
            endcase
        end
    end

    assign rd_x0     = mem_x0[rd_idx];
    assign rd_x1     = mem_x1[rd_idx];
    assign rd_target = mem_tgt[rd_idx];

endmodule

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - presents stored samples to the network for N epochs
// Purpose: walks the sample store in index order with a valid/ready
//          handshake, counting full passes until the latched epoch limit.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   wr_en, wr_idx, wr_field,        sample store write (IDLE/DONE only)
//   wr_data
//   start, abort                    run control pulses (abort wins)
//   epoch_limit                     passes per run, sampled on start
//   out_valid, out_ready            sample handshake
//   out_x0, out_x1, out_target,     presented sample and its index
//   out_idx
//   epoch_cnt                       completed epochs
//   busy, done                      in PRESENT / in DONE
module sample_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int EPOCH_W     = 16,
    localparam int IDX_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [1:0]         wr_field,
    input  logic [31:0]        wr_data,
    input  logic               start,
    input  logic               abort,
    input  logic [EPOCH_W-1:0] epoch_limit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_x0,
    output logic [31:0]        out_x1,
    output logic [31:0]        out_target,
    output logic [IDX_W-1:0]   out_idx,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    seq_state_e         state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [EPOCH_W-1:0] epoch_q;
    logic [EPOCH_W-1:0] limit_q;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               start_ok, xfer, wrap, run_end;

    assign start_ok  = start && !abort && (state != SEQ_PRESENT);
    assign xfer      = (state == SEQ_PRESENT) && out_ready;
    assign wrap      = xfer && (idx == LAST_IDX);
    assign epoch_inc = epoch_q + EPOCH_W'(1);
    // Last sample of the last epoch: leave PRESENT on this same edge.
    assign run_end   = wrap && (epoch_inc == limit_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = SEQ_IDLE;
        end else begin
            case (state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (start) begin
                        state_next = (epoch_limit == '0) ? SEQ_DONE : SEQ_PRESENT;
                    end
                end
                SEQ_PRESENT: begin
                    if (run_end) begin
                        state_next = SEQ_DONE;
                    end
                end
                default: state_next = SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            SEQ_PRESENT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            SEQ_DONE: done = 1'b1;
            default:  ;
        endcase
    end

    // Abort freezes idx and epoch count so software can see where the run stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            epoch_q <= '0;
            limit_q <= '0;
        end else if (abort) begin
            idx     <= idx;
            epoch_q <= epoch_q;
        end else if (start_ok) begin
            idx     <= '0;
            epoch_q <= '0;
            limit_q <= epoch_limit;
        end else if (xfer) begin
            if (wrap) begin
                idx     <= '0;
                epoch_q <= epoch_inc;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // The store is frozen while a run presents data so samples cannot tear.
    sample_store #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .IDX_W       (IDX_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en && (state != SEQ_PRESENT)),
        .wr_idx    (wr_idx),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .rd_idx    (idx),
        .rd_x0     (out_x0),
        .rd_x1     (out_x1),
        .rd_target (out_target)
    );

    assign out_idx   = idx;
    assign epoch_cnt = epoch_q;

endmodule
